// File: rtl/regfile_scoreboard_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
interface regfile_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int NRD    = 3,
  parameter int NIN    = 2
);
  logic [NRD*REG_W-1:0]  RD_ADDR;
  logic [NRD*DATA_W-1:0] RD_DATA;
  logic [NRD-1:0]        RD_BUSY;
  logic                  WE;
  logic [REG_W-1:0]      WADDR;
  logic [DATA_W-1:0]     WDATA;
  logic                  ISSUE;
  logic [REG_W-1:0]      ISSUE_ADDR;
  logic                  ISSUE_FULL;
  logic                  FLUSH;
  logic [NIN*DATA_W-1:0] IN_DATA;
  logic                  ERR;

  modport master (
    output RD_ADDR, WE, WADDR, WDATA, ISSUE, ISSUE_ADDR, FLUSH, IN_DATA,
    input  RD_DATA, RD_BUSY, ISSUE_FULL, ERR
  );

  modport slave (
    input  RD_ADDR, WE, WADDR, WDATA, ISSUE, ISSUE_ADDR, FLUSH, IN_DATA,
    output RD_DATA, RD_BUSY, ISSUE_FULL, ERR
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with hardwired zero register, switch-mapped
// input registers, optional write-through bypass and a per-register
// pending-write scoreboard for RAW hazard detection at decode.
module regfile_scoreboard #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int NRD     = 3,
  parameter int IN_BASE = 6,
  parameter int NIN     = 2,
  parameter int PEND_W  = 2,
  parameter int BYPASS  = 1
) (
  input  logic CLK,
  input  logic RST,
  regfile_scoreboard_if.slave bus
);

  localparam int NREG = 1 << REG_W;
  localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] CNT_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

  // Only ordinary registers accept writes and own a pending counter;
  // register 0 and the input-mapped registers are read-only.
  function automatic logic f_writable(input logic [REG_W-1:0] addr);
    int a;
    a = int'(addr);
    return (a != 0) && !((a >= IN_BASE) && (a < IN_BASE + NIN));
  endfunction

  logic [DATA_W-1:0] r_regs [NREG];
  logic [PEND_W-1:0] r_cnt  [NREG];
  logic              r_err;

  logic [PEND_W-1:0] w_cnt_nxt [NREG];
  logic [REG_W-1:0]  w_rd_addr [NRD];
  logic              w_we_ok;
  logic              w_iss_ok;
  logic              w_err_set;

  // Qualify write and issue requests; FLUSH cancels a same-cycle issue.
  always_comb begin
    w_we_ok   = bus.WE && f_writable(bus.WADDR);
    w_iss_ok  = bus.ISSUE && !bus.FLUSH && f_writable(bus.ISSUE_ADDR);
    w_err_set = w_iss_ok && (r_cnt[bus.ISSUE_ADDR] == CNT_MAX);
  end

  // Next value of every pending counter from flush/issue/retire events.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      if (bus.FLUSH) begin
        w_cnt_nxt[r] = CNT_ZERO;
      end else if (w_iss_ok && (bus.ISSUE_ADDR == REG_W'(r)) &&
                   w_we_ok  && (bus.WADDR == REG_W'(r))) begin
        // old producer retires while a new one becomes pending
        w_cnt_nxt[r] = r_cnt[r];
      end else if (w_iss_ok && (bus.ISSUE_ADDR == REG_W'(r))) begin
        if (r_cnt[r] != CNT_MAX) begin
          w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
        end else begin
          w_cnt_nxt[r] = r_cnt[r];
        end
      end else if (w_we_ok && (bus.WADDR == REG_W'(r))) begin
        if (r_cnt[r] != CNT_ZERO) begin
          w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
        end else begin
          w_cnt_nxt[r] = r_cnt[r];
        end
      end else begin
        w_cnt_nxt[r] = r_cnt[r];
      end
    end
  end

  // Register contents, pending counters and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) begin
        r_regs[r] <= {DATA_W{1'b0}};
        r_cnt[r]  <= CNT_ZERO;
      end
      r_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      if (w_we_ok) begin
        r_regs[bus.WADDR] <= bus.WDATA;
      end
      for (int j = 0; j < NIN; j++) begin
        r_regs[IN_BASE + j] <= bus.IN_DATA[j*DATA_W +: DATA_W];
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Combinational read ports with optional forwarding of the writeback.
  always_comb begin
    bus.RD_DATA = {(NRD*DATA_W){1'b0}};
    bus.RD_BUSY = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      w_rd_addr[k] = bus.RD_ADDR[k*REG_W +: REG_W];
      if (w_rd_addr[k] == {REG_W{1'b0}}) begin
        bus.RD_DATA[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if ((BYPASS != 0) && w_we_ok && (bus.WADDR == w_rd_addr[k])) begin
        bus.RD_DATA[k*DATA_W +: DATA_W] = bus.WDATA;
      end else begin
        bus.RD_DATA[k*DATA_W +: DATA_W] = r_regs[w_rd_addr[k]];
      end
      // the last outstanding write being forwarded clears the hazard early
      if ((BYPASS != 0) && bus.WE && (bus.WADDR == w_rd_addr[k]) &&
          (r_cnt[w_rd_addr[k]] == CNT_ONE)) begin
        bus.RD_BUSY[k] = 1'b0;
      end else begin
        bus.RD_BUSY[k] = (r_cnt[w_rd_addr[k]] != CNT_ZERO);
      end
    end
  end

  assign bus.ISSUE_FULL = (r_cnt[bus.ISSUE_ADDR] == CNT_MAX);
  assign bus.ERR        = r_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: two instances (bypass off / on) share stimulus and are
// compared every cycle against a behavioural model; directed literal checks
// pin the model to hand-computed values.
module tb_regfile_scoreboard;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int NRD    = 3;
  localparam int NIN    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [8:0]  t_rd_addr;
  logic        t_we;
  logic [2:0]  t_waddr;
  logic [15:0] t_wdata;
  logic        t_issue;
  logic [2:0]  t_issue_addr;
  logic        t_flush;
  logic [31:0] t_in_data;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .REG_W(REG_W), .NRD(NRD), .NIN(NIN)) bus0 ();
  regfile_scoreboard_if #(.DATA_W(DATA_W), .REG_W(REG_W), .NRD(NRD), .NIN(NIN)) bus1 ();

  assign bus0.RD_ADDR = t_rd_addr;    assign bus1.RD_ADDR = t_rd_addr;
  assign bus0.WE = t_we;              assign bus1.WE = t_we;
  assign bus0.WADDR = t_waddr;        assign bus1.WADDR = t_waddr;
  assign bus0.WDATA = t_wdata;        assign bus1.WDATA = t_wdata;
  assign bus0.ISSUE = t_issue;        assign bus1.ISSUE = t_issue;
  assign bus0.ISSUE_ADDR = t_issue_addr; assign bus1.ISSUE_ADDR = t_issue_addr;
  assign bus0.FLUSH = t_flush;        assign bus1.FLUSH = t_flush;
  assign bus0.IN_DATA = t_in_data;    assign bus1.IN_DATA = t_in_data;

  regfile_scoreboard #(.BYPASS(0)) u_dut0 (.CLK(clk), .RST(rst), .bus(bus0));
  regfile_scoreboard #(.BYPASS(1)) u_dut1 (.CLK(clk), .RST(rst), .bus(bus1));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_regs [8];
  int          m_cnt  [8];
  logic        m_err;

  function automatic bit wr(input int a);
    return (a != 0) && !(a >= 6 && a < 8);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      m_regs[r] = 16'h0000;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_step();
    int ia; int wa; bit iv; bit wv;
    ia = int'(t_issue_addr);
    wa = int'(t_waddr);
    iv = t_issue && wr(ia);
    wv = t_we && wr(wa);
    if (t_flush) begin
      for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    end else if (iv && wv && ia == wa) begin
      if (m_cnt[ia] == 3) m_err = 1'b1;
    end else begin
      if (iv) begin
        if (m_cnt[ia] == 3) m_err = 1'b1;
        else m_cnt[ia] = m_cnt[ia] + 1;
      end
      if (wv && m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
    end
    if (wv) m_regs[wa] = t_wdata;
    for (int j = 0; j < 2; j++) m_regs[6+j] = t_in_data[j*16 +: 16];
  endtask

  function automatic logic [15:0] exp_rd(input int k, input bit bp);
    int a;
    a = int'(t_rd_addr[k*3 +: 3]);
    if (a == 0) return 16'h0000;
    if (bp && t_we && wr(int'(t_waddr)) && int'(t_waddr) == a) return t_wdata;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int k, input bit bp);
    int a;
    a = int'(t_rd_addr[k*3 +: 3]);
    if (!wr(a) || m_cnt[a] == 0) return 1'b0;
    if (bp && t_we && int'(t_waddr) == a && m_cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  // Compare both instances against the model every cycle, away from the edge.
  always @(negedge clk) begin
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rd_data%0d_byp0", k), bus0.RD_DATA[k*16 +: 16], exp_rd(k, 1'b0));
      chk($sformatf("rd_data%0d_byp1", k), bus1.RD_DATA[k*16 +: 16], exp_rd(k, 1'b1));
      chk($sformatf("rd_busy%0d_byp0", k), bus0.RD_BUSY[k], exp_busy(k, 1'b0));
      chk($sformatf("rd_busy%0d_byp1", k), bus1.RD_BUSY[k], exp_busy(k, 1'b1));
    end
    chk("issue_full_byp0", bus0.ISSUE_FULL, (m_cnt[int'(t_issue_addr)] == 3));
    chk("issue_full_byp1", bus1.ISSUE_FULL, (m_cnt[int'(t_issue_addr)] == 3));
    chk("err_byp0", bus0.ERR, m_err);
    chk("err_byp1", bus1.ERR, m_err);
  end

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic set_rd(input int p0, input int p1, input int p2);
    t_rd_addr = {3'(p2), 3'(p1), 3'(p0)};
  endtask

  initial begin
    t_rd_addr = 9'd0; t_we = 1'b0; t_waddr = 3'd0; t_wdata = 16'h0000;
    t_issue = 1'b0; t_issue_addr = 3'd0; t_flush = 1'b0; t_in_data = 32'h0;
    model_reset();
    #3;
    chk("reset_rd", bus1.RD_DATA, 48'h0);
    chk("reset_busy", bus1.RD_BUSY, 3'b000);
    chk("reset_err", bus1.ERR, 1'b0);
    rst = 1'b0;
    tick();

    // reset and zero register
    t_we = 1'b1; t_waddr = 3'd2; t_wdata = 16'h1234;
    tick();
    t_we = 1'b0; set_rd(2, 0, 0);
    #1;
    chk("reg2_loaded_b0", bus0.RD_DATA[15:0], 16'h1234);
    chk("reg2_loaded_b1", bus1.RD_DATA[15:0], 16'h1234);
    rst = 1'b1; model_reset();
    #1;
    chk("async_rst_b0", bus0.RD_DATA[15:0], 16'h0000);
    chk("async_rst_b1", bus1.RD_DATA[15:0], 16'h0000);
    rst = 1'b0;
    t_we = 1'b1; t_waddr = 3'd0; t_wdata = 16'hFFFF; set_rd(0, 0, 0);
    #1;
    chk("reg0_nofwd", bus1.RD_DATA[15:0], 16'h0000);
    chk("reg0_busy", bus1.RD_BUSY, 3'b000);
    tick();
    t_we = 1'b0;
    #1;
    chk("reg0_after_wr", bus0.RD_DATA[15:0], 16'h0000);

    // bypass
    set_rd(3, 0, 0); t_we = 1'b1; t_waddr = 3'd3; t_wdata = 16'hBEEF;
    #1;
    chk("bypass_on", bus1.RD_DATA[15:0], 16'hBEEF);
    chk("bypass_off_old", bus0.RD_DATA[15:0], 16'h0000);
    tick();
    t_we = 1'b0;
    #1;
    chk("bypass_off_new", bus0.RD_DATA[15:0], 16'hBEEF);

    // scoreboard
    t_issue = 1'b1; t_issue_addr = 3'd4;
    tick(); tick();
    t_issue = 1'b0; set_rd(0, 4, 0);
    #1;
    chk("sb_busy_cnt2", bus1.RD_BUSY[1], 1'b1);
    t_we = 1'b1; t_waddr = 3'd4; t_wdata = 16'h0001;
    #1;
    chk("sb_busy_we1", bus1.RD_BUSY[1], 1'b1);
    tick();
    #1;
    chk("sb_busy_fwd_b1", bus1.RD_BUSY[1], 1'b0);
    chk("sb_busy_fwd_b0", bus0.RD_BUSY[1], 1'b1);
    tick();
    t_we = 1'b0;
    #1;
    chk("sb_cnt0_b0", bus0.RD_BUSY[1], 1'b0);
    chk("sb_cnt0_b1", bus1.RD_BUSY[1], 1'b0);

    // simultaneous events and saturation
    t_issue = 1'b1; t_issue_addr = 3'd5;
    tick();
    t_we = 1'b1; t_waddr = 3'd5; t_wdata = 16'h0005;
    tick();
    t_we = 1'b0; t_issue = 1'b0; set_rd(5, 5, 5);
    #1;
    chk("simul_busy", bus1.RD_BUSY[0], 1'b1);
    chk("simul_not_full", bus1.ISSUE_FULL, 1'b0);
    t_issue = 1'b1;
    tick(); tick();
    t_issue = 1'b0;
    #1;
    chk("sat_full", bus1.ISSUE_FULL, 1'b1);
    chk("sat_no_err", bus1.ERR, 1'b0);
    t_issue = 1'b1;
    tick();
    t_issue = 1'b0;
    #1;
    chk("sat_err_b0", bus0.ERR, 1'b1);
    chk("sat_err_b1", bus1.ERR, 1'b1);
    t_we = 1'b1; t_waddr = 3'd5;
    tick();
    t_we = 1'b0;
    #1;
    chk("sat_drop_full", bus1.ISSUE_FULL, 1'b0);
    chk("err_sticky", bus1.ERR, 1'b1);

    // flush
    t_issue = 1'b1; t_issue_addr = 3'd2;
    tick(); tick();
    t_issue_addr = 3'd3;
    tick();
    t_issue = 1'b0; set_rd(2, 3, 5);
    #1;
    chk("pre_flush_busy", bus0.RD_BUSY, 3'b111);
    t_flush = 1'b1; t_issue = 1'b1; t_issue_addr = 3'd2;
    t_we = 1'b1; t_waddr = 3'd3; t_wdata = 16'h0042;
    tick();
    t_flush = 1'b0; t_issue = 1'b0; t_we = 1'b0;
    #1;
    chk("flush_busy_b0", bus0.RD_BUSY, 3'b000);
    chk("flush_busy_b1", bus1.RD_BUSY, 3'b000);
    chk("flush_wr_reg3", bus0.RD_DATA[31:16], 16'h0042);

    // input registers
    t_in_data = {16'h00A5, 16'h005A}; set_rd(6, 7, 0);
    #1;
    chk("in_latency", bus1.RD_DATA[15:0], 16'h0000);
    tick();
    chk("in_reg6", bus1.RD_DATA[15:0], 16'h005A);
    chk("in_reg7", bus1.RD_DATA[31:16], 16'h00A5);
    t_we = 1'b1; t_waddr = 3'd6; t_wdata = 16'h1111;
    #1;
    chk("in_we_nofwd", bus1.RD_DATA[15:0], 16'h005A);
    tick();
    t_we = 1'b0;
    #1;
    chk("in_we_ignored", bus0.RD_DATA[15:0], 16'h005A);
    t_issue = 1'b1; t_issue_addr = 3'd7;
    tick();
    t_issue = 1'b0;
    #1;
    chk("in_issue_nobusy", bus1.RD_BUSY[1], 1'b0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      t_rd_addr    = 9'($urandom);
      t_we         = ($urandom_range(0, 9) < 4);
      t_waddr      = 3'($urandom);
      t_wdata      = 16'($urandom);
      t_issue      = ($urandom_range(0, 9) < 5);
      t_issue_addr = 3'($urandom);
      t_flush      = ($urandom_range(0, 39) == 0);
      t_in_data    = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b1; model_reset();
        #1;
        rst = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
